// File: rtl/display_and_process.sv
// Piano-tuner note player: debounced buttons, octave register, tone generator, 8-step tune, 4-digit display.
// Optional FILE_LOOP_EN: the tune repeats forever and a start press while it plays stops it.
module display_and_process #(
  parameter int DEBOUNCE_CYCLES  = 1024,
  parameter int REFRESH_CYCLES   = 50000,
  parameter int FILE_NOTE_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       playBtn,
  input  logic       rightOctaveBtn,
  input  logic       leftOctaveBtn,
  input  logic       playFileBtn,
  input  logic [7:0] note,
  output logic [7:0] segDisplay,
  output logic [3:0] anodeNum,
  output logic       Speaker,
  output logic [2:0] octaveOutput,
  output logic       currNoteOutput,
  output logic       currFileOutput,
  output logic       fileOutput,
  output logic       playOutput,
  output logic       rightOutput
);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RCW = $clog2(REFRESH_CYCLES + 1);
  localparam int FCW = $clog2(FILE_NOTE_CYCLES + 1);

  typedef enum logic {T_IDLE, T_PLAY} tune_state_e;

  // Button order in the vectors: [0]=play, [1]=right, [2]=left, [3]=playFile
  logic [3:0]     raw, db_q, db_prev_q, rise;
  logic [DBW-1:0] db_cnt_q [4];

  assign raw  = {playFileBtn, leftOctaveBtn, rightOctaveBtn, playBtn};
  assign rise = db_q & ~db_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      db_prev_q <= db_q;
      for (int i = 0; i < 4; i++) begin
        if (raw[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          db_q[i]     <= raw[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic [2:0] oct_q, oct_d;

  always_comb begin
    oct_d = oct_q;
    if (rise[1] && !rise[2] && oct_q != 3'd7)      oct_d = oct_q + 3'd1;
    else if (rise[2] && !rise[1] && oct_q != 3'd0) oct_d = oct_q - 3'd1;
  end

  tune_state_e    state_q, state_d;
  logic [2:0]     step_q, step_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           cfile_q, cfile_d;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    fcnt_d  = fcnt_q;
    cfile_d = cfile_q;
    case (state_q)
      T_IDLE: begin
        if (rise[3]) begin
          state_d = T_PLAY;
          step_d  = 3'd0;
          fcnt_d  = '0;
        end
      end
      default: begin
        if (rise[3]) begin
`ifdef FILE_LOOP_EN
          state_d = T_IDLE;
`endif
          step_d  = 3'd0;
          fcnt_d  = '0;
        end else if (fcnt_q == FCW'(FILE_NOTE_CYCLES - 1)) begin
          fcnt_d  = '0;
          cfile_d = ~cfile_q;
          step_d  = step_q + 3'd1;
`ifndef FILE_LOOP_EN
          if (step_q == 3'd7) state_d = T_IDLE;
`endif
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
    endcase
  end

  // Sounding note: index 0..7 = C D E F G A B C'
  logic       src_valid;
  logic [2:0] src_idx;

  always_comb begin
    src_valid = 1'b0;
    src_idx   = 3'd0;
    if (state_q == T_PLAY) begin
      src_valid = 1'b1;
      src_idx   = step_q;
    end else if (db_q[0] && note != 8'd0) begin
      src_valid = 1'b1;
      for (int i = 0; i < 8; i++) if (note[i]) src_idx = 3'(7 - i);
    end
  end

  function automatic logic [23:0] base_period(input logic [2:0] idx);
    case (idx)
      3'd0:    base_period = 24'd95556;
      3'd1:    base_period = 24'd85131;
      3'd2:    base_period = 24'd75843;
      3'd3:    base_period = 24'd71586;
      3'd4:    base_period = 24'd63776;
      3'd5:    base_period = 24'd56818;
      3'd6:    base_period = 24'd50619;
      default: base_period = 24'd47778;
    endcase
  endfunction

  logic [23:0] half_period;
  always_comb begin
    if (oct_q >= 3'd4) half_period = base_period(src_idx) >> (oct_q - 3'd4);
    else               half_period = base_period(src_idx) << (3'd4 - oct_q);
  end

  // Period is latched at each reload, so octave changes land on the next tone period
  logic [3:0]  key_q, key_d;
  logic [23:0] tcnt_q, tcnt_d, period_q, period_d;
  logic        tone_q, tone_d;

  assign key_d = {src_valid, src_idx};

  always_comb begin
    tcnt_d   = tcnt_q + 24'd1;
    tone_d   = tone_q;
    period_d = period_q;
    if (!src_valid || key_d != key_q) begin
      tcnt_d   = 24'd0;
      tone_d   = 1'b0;
      period_d = half_period;
    end else if (tcnt_q == period_q - 24'd1) begin
      tcnt_d   = 24'd0;
      tone_d   = ~tone_q;
      period_d = half_period;
    end
  end

  function automatic logic [7:0] seg_digit(input logic [2:0] d);
    case (d)
      3'd0:    seg_digit = 8'hC0;
      3'd1:    seg_digit = 8'hF9;
      3'd2:    seg_digit = 8'hA4;
      3'd3:    seg_digit = 8'hB0;
      3'd4:    seg_digit = 8'h99;
      3'd5:    seg_digit = 8'h92;
      3'd6:    seg_digit = 8'h82;
      default: seg_digit = 8'hF8;
    endcase
  endfunction

  function automatic logic [7:0] seg_letter(input logic [2:0] idx);
    case (idx)
      3'd1:    seg_letter = 8'hA1;
      3'd2:    seg_letter = 8'h86;
      3'd3:    seg_letter = 8'h8E;
      3'd4:    seg_letter = 8'hC2;
      3'd5:    seg_letter = 8'h88;
      3'd6:    seg_letter = 8'h83;
      default: seg_letter = 8'hC6;
    endcase
  endfunction

  logic [RCW-1:0] rcnt_q;
  logic [1:0]     digit_q;
  logic [7:0]     seg_q, seg_d;
  logic [3:0]     anode_q;

  always_comb begin
    seg_d = 8'hFF;
    case (digit_q)
      2'd0:    seg_d = seg_digit(oct_q);
      2'd1:    seg_d = src_valid ? seg_letter(src_idx) : 8'hFF;
      default: seg_d = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oct_q    <= 3'd4;
      state_q  <= T_IDLE;
      step_q   <= 3'd0;
      fcnt_q   <= '0;
      cfile_q  <= 1'b0;
      key_q    <= 4'd0;
      tcnt_q   <= 24'd0;
      period_q <= 24'd0;
      tone_q   <= 1'b0;
      rcnt_q   <= '0;
      digit_q  <= 2'd0;
      seg_q    <= 8'hFF;
      anode_q  <= 4'b1110;
    end else begin
      oct_q    <= oct_d;
      state_q  <= state_d;
      step_q   <= step_d;
      fcnt_q   <= fcnt_d;
      cfile_q  <= cfile_d;
      key_q    <= key_d;
      tcnt_q   <= tcnt_d;
      period_q <= period_d;
      tone_q   <= tone_d;
      if (rcnt_q == RCW'(REFRESH_CYCLES - 1)) begin
        rcnt_q  <= '0;
        digit_q <= digit_q + 2'd1;
      end else begin
        rcnt_q <= rcnt_q + 1'b1;
      end
      seg_q   <= seg_d;
      anode_q <= ~(4'b0001 << digit_q);
    end
  end

  assign segDisplay     = seg_q;
  assign anodeNum       = anode_q;
  assign Speaker        = tone_q;
  assign currNoteOutput = tone_q;
  assign octaveOutput   = oct_q;
  assign currFileOutput = cfile_q;
  assign fileOutput     = (state_q == T_PLAY);
  assign playOutput     = db_q[0];
  assign rightOutput    = db_q[1];
endmodule

// File: tb/tb_display_and_process.sv
// Directed bench for display_and_process with shortened debounce, refresh and tune-step periods.
module tb_display_and_process;
  localparam int DB = 64;
  localparam int RF = 100;
  localparam int FN = 1000;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       playBtn = 1'b0, rightOctaveBtn = 1'b0, leftOctaveBtn = 1'b0, playFileBtn = 1'b0;
  logic [7:0] note = 8'd0;
  logic [7:0] segDisplay;
  logic [3:0] anodeNum;
  logic       Speaker, currNoteOutput, currFileOutput, fileOutput, playOutput, rightOutput;
  logic [2:0] octaveOutput;

  int n_cmp = 0;
  int n_bad = 0;

  display_and_process #(.DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RF), .FILE_NOTE_CYCLES(FN)) dut (
    .clk(clk), .rst_n(rst_n), .playBtn(playBtn), .rightOctaveBtn(rightOctaveBtn),
    .leftOctaveBtn(leftOctaveBtn), .playFileBtn(playFileBtn), .note(note),
    .segDisplay(segDisplay), .anodeNum(anodeNum), .Speaker(Speaker), .octaveOutput(octaveOutput),
    .currNoteOutput(currNoteOutput), .currFileOutput(currFileOutput), .fileOutput(fileOutput),
    .playOutput(playOutput), .rightOutput(rightOutput)
  );

  always #10 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [3:0] b);
    {playFileBtn, leftOctaveBtn, rightOctaveBtn, playBtn} = b;
  endtask

  task automatic press(input logic [3:0] b);
    set_btns(b);
    cyc(DB + 20);
    set_btns(4'b0000);
    cyc(DB + 20);
  endtask

  task automatic wait_anode(input logic [3:0] an, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * RF + 20; i++) begin
      if (anodeNum == an) begin
        ok = 1'b1;
        return;
      end
      cyc(1);
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_an [4];
    bit ok;
    exp_an = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst_n = 1'b0;
    #100;
    n_cmp++; if (octaveOutput !== 3'd4) begin n_bad++; $display("FAIL reset_octave: got %0d want 4", octaveOutput); end
    n_cmp++; if (Speaker !== 1'b0) begin n_bad++; $display("FAIL reset_speaker: got %b want 0", Speaker); end
    n_cmp++; if (fileOutput !== 1'b0 || currFileOutput !== 1'b0) begin n_bad++; $display("FAIL reset_file: got %b%b want 00", fileOutput, currFileOutput); end
    n_cmp++; if (anodeNum !== 4'b1110) begin n_bad++; $display("FAIL reset_anode: got %b want 1110", anodeNum); end
    n_cmp++; if (segDisplay !== 8'hFF) begin n_bad++; $display("FAIL reset_seg: got %h want ff", segDisplay); end
    @(negedge clk) rst_n = 1'b1;
    cyc(5);
    n_cmp++; if (anodeNum !== 4'b1110 || segDisplay !== 8'h99) begin n_bad++; $display("FAIL digit0_after_reset: got %b/%h want 1110/99", anodeNum, segDisplay); end
    for (int k = 0; k < 4; k++) begin
      wait_anode(exp_an[k], ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL anode_cycle%0d: got %b want %b", k, anodeNum, exp_an[k]); end
      if (k < 3) begin
        n_cmp++; if (segDisplay !== 8'hFF) begin n_bad++; $display("FAIL blank_digit%0d: got %h want ff", k + 1, segDisplay); end
      end
    end
  endtask

  task automatic test_debounce;
    note = 8'h80;
    rightOctaveBtn = 1'b1;
    cyc(DB - 4);
    n_cmp++; if (rightOutput !== 1'b0) begin n_bad++; $display("FAIL debounce_early: got %b want 0", rightOutput); end
    cyc(8);
    n_cmp++; if (rightOutput !== 1'b1) begin n_bad++; $display("FAIL debounce_high: got %b want 1", rightOutput); end
    cyc(4);
    n_cmp++; if (octaveOutput !== 3'd5) begin n_bad++; $display("FAIL octave_up: got %0d want 5", octaveOutput); end
    cyc(DB);
    n_cmp++; if (octaveOutput !== 3'd5) begin n_bad++; $display("FAIL octave_once: got %0d want 5", octaveOutput); end
    rightOctaveBtn = 1'b0;
    cyc(DB + 20);
    n_cmp++; if (rightOutput !== 1'b0 || octaveOutput !== 3'd5) begin n_bad++; $display("FAIL release: got %b/%0d want 0/5", rightOutput, octaveOutput); end
    note = 8'h00;
  endtask

  task automatic test_octave_sat;
    int exp_o = 5;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      press(4'b0010);
      exp_o = (exp_o < 7) ? exp_o + 1 : 7;
      n_cmp++; if (octaveOutput !== 3'(exp_o)) begin n_bad++; $display("FAIL right_sat%0d: got %0d want %0d", i, octaveOutput, exp_o); end
    end
    wait_anode(4'b1110, ok);
    n_cmp++; if (!ok || segDisplay !== 8'hF8) begin n_bad++; $display("FAIL digit0_oct7: got %h want f8", segDisplay); end
    for (int i = 0; i < 8; i++) begin
      press(4'b0100);
      exp_o = (exp_o > 0) ? exp_o - 1 : 0;
      n_cmp++; if (octaveOutput !== 3'(exp_o)) begin n_bad++; $display("FAIL left_sat%0d: got %0d want %0d", i, octaveOutput, exp_o); end
    end
    press(4'b0010);
    press(4'b0110);
    n_cmp++; if (octaveOutput !== 3'd1) begin n_bad++; $display("FAIL both_pressed: got %0d want 1", octaveOutput); end
    for (int i = 0; i < 3; i++) press(4'b0010);
    n_cmp++; if (octaveOutput !== 3'd4) begin n_bad++; $display("FAIL back_to_4: got %0d want 4", octaveOutput); end
  endtask

  task automatic test_live_tone;
    int  k = 0;
    bit  seen = 1'b0;
    bit  ok;
    playBtn = 1'b1;
    cyc(DB + 20);
    n_cmp++; if (playOutput !== 1'b1 || Speaker !== 1'b0) begin n_bad++; $display("FAIL play_no_note: got %b/%b want 1/0", playOutput, Speaker); end
    note = 8'h04;
    cyc(1);
    while (k < 60000) begin
      cyc(1);
      k++;
      if (!seen && k > 2 && anodeNum == 4'b1101) begin
        seen = 1'b1;
        n_cmp++; if (segDisplay !== 8'h88) begin n_bad++; $display("FAIL letter_A: got %h want 88", segDisplay); end
      end
      if (Speaker === 1'b1) break;
    end
    n_cmp++; if (k != 56818) begin n_bad++; $display("FAIL half_period_A4: got %0d want 56818", k); end
    note = 8'h06;
    cyc(2);
    n_cmp++; if (Speaker !== 1'b1) begin n_bad++; $display("FAIL no_restart_same_note: got %b want 1", Speaker); end
    wait_anode(4'b1101, ok);
    n_cmp++; if (!ok || segDisplay !== 8'h88) begin n_bad++; $display("FAIL highest_bit_A: got %h want 88", segDisplay); end
    note = 8'h81;
    cyc(2);
    n_cmp++; if (Speaker !== 1'b0) begin n_bad++; $display("FAIL restart_on_change: got %b want 0", Speaker); end
    wait_anode(4'b1101, ok);
    n_cmp++; if (!ok || segDisplay !== 8'hC6) begin n_bad++; $display("FAIL letter_C: got %h want c6", segDisplay); end
    note = 8'h00;
    cyc(2);
    n_cmp++; if (Speaker !== 1'b0 || currNoteOutput !== 1'b0) begin n_bad++; $display("FAIL note_zero: got %b/%b want 0/0", Speaker, currNoteOutput); end
    wait_anode(4'b1101, ok);
    n_cmp++; if (!ok || segDisplay !== 8'hFF) begin n_bad++; $display("FAIL letter_blank: got %h want ff", segDisplay); end
    playBtn = 1'b0;
    cyc(DB + 20);
    n_cmp++; if (playOutput !== 1'b0) begin n_bad++; $display("FAIL play_release: got %b want 0", playOutput); end
  endtask

  task automatic test_file_tune;
    logic [7:0] letters [8];
    logic prev_cf;
    int   t = 0, toggles = 0, k = 0, checked = 0;
    bit   seen = 1'b0;
    letters = '{8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hC2, 8'h88, 8'h83, 8'hC6};
    playFileBtn = 1'b1;
    while (k < DB + 20 && fileOutput !== 1'b1) begin cyc(1); k++; end
    n_cmp++; if (fileOutput !== 1'b1) begin n_bad++; $display("FAIL tune_start: got %b want 1", fileOutput); end
    prev_cf = currFileOutput;
    for (int i = 0; i < 9 * FN; i++) begin
      cyc(1);
      t++;
      if (toggles == 0 && t == 50) playFileBtn = 1'b0;
      if (currFileOutput !== prev_cf) begin
        n_cmp++; if (t != FN) begin n_bad++; $display("FAIL step_len%0d: got %0d want %0d", toggles, t, FN); end
        prev_cf = currFileOutput;
        toggles++;
        t = 0;
        seen = 1'b0;
      end
      if (fileOutput !== 1'b1) break;
      if (!seen && t >= 10 && anodeNum == 4'b1101 && toggles < 8) begin
        seen = 1'b1;
        checked++;
        n_cmp++; if (segDisplay !== letters[toggles]) begin n_bad++; $display("FAIL tune_letter%0d: got %h want %h", toggles, segDisplay, letters[toggles]); end
      end
    end
    n_cmp++; if (toggles != 8) begin n_bad++; $display("FAIL tune_toggles: got %0d want 8", toggles); end
    n_cmp++; if (checked != 8) begin n_bad++; $display("FAIL tune_letters_seen: got %0d want 8", checked); end
    n_cmp++; if (fileOutput !== 1'b0 || Speaker !== 1'b0) begin n_bad++; $display("FAIL tune_end: got %b/%b want 0/0", fileOutput, Speaker); end
  endtask

  task automatic test_reset_mid_tune;
    int k = 0;
    press(4'b0010);
    playFileBtn = 1'b1;
    while (k < DB + 20 && fileOutput !== 1'b1) begin cyc(1); k++; end
    cyc(100);
    playFileBtn = 1'b0;
    cyc(3400);
    n_cmp++; if (fileOutput !== 1'b1 || currFileOutput !== 1'b1 || octaveOutput !== 3'd5) begin n_bad++; $display("FAIL pre_reset: got %b/%b/%0d want 1/1/5", fileOutput, currFileOutput, octaveOutput); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (Speaker !== 1'b0 || fileOutput !== 1'b0 || currFileOutput !== 1'b0) begin n_bad++; $display("FAIL async_reset_outs: got %b/%b/%b want 0/0/0", Speaker, fileOutput, currFileOutput); end
    n_cmp++; if (octaveOutput !== 3'd4 || anodeNum !== 4'b1110 || segDisplay !== 8'hFF) begin n_bad++; $display("FAIL async_reset_state: got %0d/%b/%h want 4/1110/ff", octaveOutput, anodeNum, segDisplay); end
    @(negedge clk) rst_n = 1'b1;
    cyc(5);
  endtask

  initial begin
    test_reset;
    test_debounce;
    test_octave_sat;
    test_live_tone;
    test_file_tune;
    test_reset_mid_tune;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
